// File: rtl/instr_encoder.sv
// Packs symbolic CPU instructions into 32-bit words, queues them and writes them to instruction memory.
// Optional `ENC_STATS_EN adds ISSUED/DROPPED saturating counters.
module instr_encoder #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic [7:0]        REQ_OP,
    input  logic [2:0]        REQ_DEST,
    input  logic [2:0]        REQ_SRC1,
    input  logic [2:0]        REQ_SRC2,
    input  logic [7:0]        REQ_IMM,
    output logic              WR_EN,
    output logic [ADDR_W-1:0] WR_ADDR,
    output logic [31:0]       WR_DATA,
    input  logic              WR_ACK,
    output logic              ERR
`ifdef ENC_STATS_EN
    ,
    output logic [15:0]       ISSUED,
    output logic [7:0]        DROPPED
`endif
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    typedef enum logic [0:0] {S_IDLE, S_WRITE} state_t;

    state_t             r_state;
    logic [31:0]        r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_full;
    logic               w_op_ok;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic [PTR_W-1:0]   w_rptr_nxt;
    logic [31:0]        w_enc;

    assign w_full     = (r_count == CNT_W'(DEPTH));
    assign REQ_READY  = !w_full;
    assign w_op_ok    = (REQ_OP[7:3] == 5'd0);
    assign w_accept   = REQ_VALID && REQ_READY;
    assign w_push     = w_accept && w_op_ok;
    assign w_pop      = (r_state == S_WRITE) && WR_ACK;
    assign w_rptr_nxt = r_rptr + PTR_W'(1);

    // Instruction field packing by opcode
    always_comb begin
        w_enc = 32'h0;
        case (REQ_OP[2:0])
            3'd0, 3'd1, 3'd2, 3'd3:
                w_enc = {REQ_OP, 5'b0, REQ_DEST, 5'b0, REQ_SRC1, 5'b0, REQ_SRC2};
            3'd4:    w_enc = {REQ_OP, 5'b0, REQ_DEST, 8'h00, 5'b0, REQ_SRC1};
            3'd5:    w_enc = {REQ_OP, 5'b0, REQ_DEST, 8'h00, REQ_IMM};
            3'd6:    w_enc = {REQ_OP, REQ_IMM, 8'h00, 8'h00};
            default: w_enc = {REQ_OP, REQ_IMM, 5'b0, REQ_SRC1, 5'b0, REQ_SRC2};
        endcase
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_enc;
        end
    end

    // FIFO pointers, occupancy and sticky error
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            ERR     <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= w_rptr_nxt;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (w_accept && !w_op_ok) begin
                ERR <= 1'b1;
            end
        end
    end

    // Write-side FSM; head entry stays queued until the memory acknowledges it
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_IDLE;
            WR_EN   <= 1'b0;
            WR_DATA <= 32'h0;
            WR_ADDR <= BASE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_count != CNT_W'(0)) begin
                        WR_DATA <= r_mem[r_rptr];
                        WR_EN   <= 1'b1;
                        r_state <= S_WRITE;
                    end
                end
                default: begin
                    if (WR_ACK) begin
                        WR_ADDR <= WR_ADDR + ADDR_W'(4);
                        if (r_count > CNT_W'(1)) begin
                            WR_DATA <= r_mem[w_rptr_nxt];
                        end else begin
                            WR_EN   <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end
            endcase
        end
    end

`ifdef ENC_STATS_EN
    // Saturating issue/drop statistics
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ISSUED  <= 16'h0;
            DROPPED <= 8'h0;
        end else begin
            if (w_pop && (ISSUED != 16'hFFFF)) begin
                ISSUED <= ISSUED + 16'd1;
            end
            if (w_accept && !w_op_ok && (DROPPED != 8'hFF)) begin
                DROPPED <= DROPPED + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: expected writes are queued at acceptance, a monitor checks each acked write.
module tb_instr_encoder;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        REQ_VALID = 1'b0;
    logic        REQ_READY;
    logic [7:0]  REQ_OP = 8'h0;
    logic [2:0]  REQ_DEST = 3'd0;
    logic [2:0]  REQ_SRC1 = 3'd0;
    logic [2:0]  REQ_SRC2 = 3'd0;
    logic [7:0]  REQ_IMM = 8'h0;
    logic        WR_EN;
    logic [9:0]  WR_ADDR;
    logic [31:0] WR_DATA;
    logic        WR_ACK = 1'b0;
    logic        ERR;
`ifdef ENC_STATS_EN
    logic [15:0] ISSUED;
    logic [7:0]  DROPPED;
`endif

    instr_encoder dut (
        .CLK(CLK), .RESET(RESET),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_OP(REQ_OP), .REQ_DEST(REQ_DEST), .REQ_SRC1(REQ_SRC1),
        .REQ_SRC2(REQ_SRC2), .REQ_IMM(REQ_IMM),
        .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
        .WR_ACK(WR_ACK), .ERR(ERR)
`ifdef ENC_STATS_EN
        , .ISSUED(ISSUED), .DROPPED(DROPPED)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t        sb_q[$];
    int         n_total = 0;
    int         n_pass  = 0;
    logic [9:0] exp_addr = 10'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Monitor: a write completes on the next posedge whenever WR_EN and WR_ACK are both high
    always @(negedge CLK) begin
        if (!RESET && WR_EN && WR_ACK) begin
            if (sb_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_write: got addr %h data %h, expected no write", WR_ADDR, WR_DATA);
            end else begin
                wr_t e;
                e = sb_q.pop_front();
                check("wr_addr", 32'(WR_ADDR), 32'(e.addr));
                check("wr_data", WR_DATA, e.data);
            end
        end
    end

    task automatic do_reset();
        RESET = 1'b1;
        REQ_VALID = 1'b0;
        WR_ACK = 1'b0;
        sb_q.delete();
        exp_addr = 10'd0;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
    endtask

    task automatic send(input logic [7:0] op, input logic [2:0] d, input logic [2:0] s1,
                        input logic [2:0] s2, input logic [7:0] imm, input logic [31:0] exp_word);
        bit ok;
        ok = 1'b0;
        REQ_OP = op; REQ_DEST = d; REQ_SRC1 = s1; REQ_SRC2 = s2; REQ_IMM = imm;
        REQ_VALID = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge CLK);
            if (REQ_READY) begin
                @(posedge CLK);
                #1 ok = 1'b1;
            end
        end
        REQ_VALID = 1'b0;
        if (!ok) begin
            n_total++;
            $display("FAIL accept_timeout: got READY low for 50 cycles, expected acceptance of op %h", op);
        end else if (op <= 8'h07) begin
            sb_q.push_back({exp_addr, exp_word});
            exp_addr = exp_addr + 10'd4;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(posedge CLK);
        #1 check("drain_empty", 32'(sb_q.size()), 32'd0);
        @(posedge CLK);
        #1 check("drain_idle_wr_en", 32'(WR_EN), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] d, s1, s2;

        // Reset state
        do_reset();
        check("rst_wr_en", 32'(WR_EN), 32'd0);
        check("rst_wr_data", WR_DATA, 32'h0);
        check("rst_wr_addr", 32'(WR_ADDR), 32'd0);
        check("rst_err", 32'(ERR), 32'd0);
        check("rst_ready", 32'(REQ_READY), 32'd1);

        // Single ADD, latency and one-cycle write strobe
        WR_ACK = 1'b1;
        send(8'h00, 3'd3, 3'd1, 3'd2, 8'h00, 32'h00030102);
        check("t1_wr_en_edge_n", 32'(WR_EN), 32'd0);
        @(posedge CLK); #1;
        check("t1_wr_en_edge_n1", 32'(WR_EN), 32'd1);
        check("t1_wr_data", WR_DATA, 32'h00030102);
        @(posedge CLK); #1;
        check("t1_wr_en_drop", 32'(WR_EN), 32'd0);

        // Remaining opcode formats, ACK held high
        do_reset();
        WR_ACK = 1'b1;
        send(8'h05, 3'd4, 3'd0, 3'd0, 8'h5A, 32'h0504005A);
        send(8'h06, 3'd0, 3'd0, 3'd0, 8'hFE, 32'h06FE0000);
        send(8'h04, 3'd2, 3'd5, 3'd0, 8'h00, 32'h04020005);
        send(8'h07, 3'd0, 3'd1, 3'd2, 8'h03, 32'h07030102);
        send(8'h02, 3'd7, 3'd6, 3'd5, 8'h00, 32'h02070605);
        send(8'h03, 3'd0, 3'd7, 3'd7, 8'h00, 32'h03000707);
        drain();
`ifdef ENC_STATS_EN
        check("t2_issued", 32'(ISSUED), 32'd6);
`endif

        // Full FIFO with ACK low, then a single ACK
        do_reset();
        WR_ACK = 1'b0;
        send(8'h00, 3'd1, 3'd1, 3'd1, 8'h00, 32'h00010101);
        send(8'h01, 3'd2, 3'd2, 3'd2, 8'h00, 32'h01020202);
        send(8'h02, 3'd3, 3'd3, 3'd3, 8'h00, 32'h02030303);
        send(8'h03, 3'd4, 3'd4, 3'd4, 8'h00, 32'h03040404);
        check("t3_ready_full", 32'(REQ_READY), 32'd0);
        repeat (3) @(posedge CLK);
        #1;
        check("t3_hold_wr_en", 32'(WR_EN), 32'd1);
        check("t3_hold_data", WR_DATA, 32'h00010101);
        check("t3_hold_addr", 32'(WR_ADDR), 32'd0);
        check("t3_hold_ready", 32'(REQ_READY), 32'd0);
        WR_ACK = 1'b1;
        @(posedge CLK);
        #1 WR_ACK = 1'b0;
        check("t3_ready_after_pop", 32'(REQ_READY), 32'd1);
        check("t3_addr_after_pop", 32'(WR_ADDR), 32'd4);
        check("t3_b2b_wr_en", 32'(WR_EN), 32'd1);
        check("t3_b2b_data", WR_DATA, 32'h01020202);
        WR_ACK = 1'b1;
        drain();

        // Invalid opcode: sticky ERR, nothing written
        do_reset();
        WR_ACK = 1'b1;
        send(8'h09, 3'd1, 3'd1, 3'd1, 8'h11, 32'h0);
        check("t4_err_set", 32'(ERR), 32'd1);
        repeat (2) begin
            @(posedge CLK); #1;
            check("t4_no_write", 32'(WR_EN), 32'd0);
        end
        send(8'h01, 3'd1, 3'd2, 3'd3, 8'h00, 32'h01010203);
        drain();
        check("t4_err_sticky", 32'(ERR), 32'd1);
`ifdef ENC_STATS_EN
        check("t4_dropped", 32'(DROPPED), 32'd1);
`endif

        // Address wrap: 260 words cross the 10-bit byte-address boundary
        do_reset();
        WR_ACK = 1'b1;
        for (int i = 0; i < 260; i++) begin
            d  = 3'(i);
            s1 = 3'(i >> 3);
            s2 = 3'(i >> 6);
            send(8'h00, d, s1, s2, 8'h00, {8'h00, 5'b0, d, 5'b0, s1, 5'b0, s2});
        end
        drain();
        check("t5_addr_wrapped", 32'(WR_ADDR), 32'd16);

        // Reset in the middle of a write with entries queued
        do_reset();
        WR_ACK = 1'b0;
        send(8'h00, 3'd1, 3'd2, 3'd3, 8'h00, 32'h00010203);
        send(8'h00, 3'd2, 3'd3, 3'd4, 8'h00, 32'h00020304);
        send(8'h00, 3'd3, 3'd4, 3'd5, 8'h00, 32'h00030405);
        check("t6_writing", 32'(WR_EN), 32'd1);
        #2 RESET = 1'b1;
        #1;
        check("t6_wr_en_async_drop", 32'(WR_EN), 32'd0);
        check("t6_addr_async_base", 32'(WR_ADDR), 32'd0);
        sb_q.delete();
        exp_addr = 10'd0;
        @(posedge CLK);
        #1 RESET = 1'b0;
        WR_ACK = 1'b1;
        repeat (5) begin
            @(posedge CLK); #1;
            check("t6_no_write_after_rst", 32'(WR_EN), 32'd0);
        end
        send(8'h01, 3'd5, 3'd6, 3'd7, 8'h00, 32'h01050607);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
